// File: rtl/reg_bank.sv
// Register bank with write-back bypass and per-register load scoreboard.
// r0 reads zero; stall is raised while a consumed source is still pending.
module reg_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              ra_use,
    input  logic              rb_use,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic              stall
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pend;

    logic w_wen;
    logic w_hit_a;
    logic w_hit_b;

    assign w_wen   = we && (w_addr != '0);
    assign w_hit_a = we && (w_addr == ra_addr);
    assign w_hit_b = we && (w_addr == rb_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_wen) begin
                r_regs[w_addr] <= w_data;
            end
            r_pend[0] <= 1'b0;
            // A claim beats a landing write: the claim is the younger load.
            for (int i = 1; i < NREGS; i++) begin
                if (claim && (claim_addr == ADDR_W'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (we && (w_addr == ADDR_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        ra_data = '0;
        if (ra_addr != '0) begin
            ra_data = w_hit_a ? w_data : r_regs[ra_addr];
        end
    end

    always_comb begin
        rb_data = '0;
        if (rb_addr != '0) begin
            rb_data = w_hit_b ? w_data : r_regs[rb_addr];
        end
    end

    assign ra_busy = r_pend[ra_addr] & ~w_hit_a;
    assign rb_busy = r_pend[rb_addr] & ~w_hit_b;
    assign stall   = (ra_use & ra_busy) | (rb_use & rb_busy);

endmodule
